// File: rtl/ft601_fifo_slv.sv
// FT601-side responder for the 245 synchronous FIFO bus: answers a FIFO master
// with TXE_N/RXF_N and read data, and bridges to local upstream/downstream buffers.
package pkg_ft601_ctrl_defines;
  localparam int WIDTH_DATA = 32;
  localparam int CNT_BE     = 4;
endpackage

module ft601_fifo_slv
  import pkg_ft601_ctrl_defines::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [WIDTH_DATA-1:0]   i_data,
  output logic [WIDTH_DATA-1:0]   o_data,
  output logic                    o_dataOe,
  input  logic [CNT_BE-1:0]       i_be,
  output logic [CNT_BE-1:0]       o_be,
  output logic                    o_beOe,
  input  logic                    i_wrN,
  input  logic                    i_rdN,
  input  logic                    i_oeN,
  output logic                    o_txeN,
  output logic                    o_rxfN,
  output logic [WIDTH_DATA-1:0]   o_upData,
  output logic [CNT_BE-1:0]       o_upBe,
  output logic                    o_upValid,
  input  logic                    i_upReady,
  input  logic [WIDTH_DATA-1:0]   i_dnData,
  input  logic [CNT_BE-1:0]       i_dnBe,
  input  logic                    i_dnValid,
  output logic                    o_dnReady,
  output logic [$clog2(DEPTH):0]  o_upLevel,
  output logic [$clog2(DEPTH):0]  o_dnLevel,
  output logic                    o_protoErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = WIDTH_DATA + CNT_BE;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WW-1:0] r_upMem [DEPTH];
  logic [WW-1:0] r_dnMem [DEPTH];
  logic [AW:0]   r_upWrPtr, r_upRdPtr, r_dnWrPtr, r_dnRdPtr;
  logic          r_txeN, r_rxfN, r_dataOe, r_protoErr;

  logic          w_contention, w_wrXfer, w_rdXfer, w_upPop, w_dnPush;
  logic [AW:0]   w_upLevel, w_dnLevel, w_upLevelNext, w_dnLevelNext;
  logic [WW-1:0] w_upHead, w_dnHead;

  assign w_upLevel = r_upWrPtr - r_upRdPtr;
  assign w_dnLevel = r_dnWrPtr - r_dnRdPtr;

  // A write strobe while we drive (or are asked to drive) the bus is contention.
  assign w_contention = ~i_wrN & (~i_oeN | r_dataOe);
  assign w_wrXfer     = ~i_wrN & ~r_txeN & i_oeN & ~r_dataOe;
  assign w_rdXfer     = ~i_rdN & ~i_oeN & r_dataOe & ~r_rxfN & i_wrN;
  assign w_upPop      = (w_upLevel != '0) & i_upReady;
  assign o_dnReady    = (w_dnLevel != LVL_FULL) & ~i_rst;
  assign w_dnPush     = i_dnValid & o_dnReady;

  assign w_upLevelNext = w_upLevel + {{AW{1'b0}}, w_wrXfer} - {{AW{1'b0}}, w_upPop};
  assign w_dnLevelNext = w_dnLevel + {{AW{1'b0}}, w_dnPush} - {{AW{1'b0}}, w_rdXfer};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_upWrPtr  <= '0;
      r_upRdPtr  <= '0;
      r_dnWrPtr  <= '0;
      r_dnRdPtr  <= '0;
      r_txeN     <= 1'b1;
      r_rxfN     <= 1'b1;
      r_dataOe   <= 1'b0;
      r_protoErr <= 1'b0;
    end else begin
      if (w_wrXfer) r_upWrPtr <= r_upWrPtr + 1'b1;
      if (w_upPop)  r_upRdPtr <= r_upRdPtr + 1'b1;
      if (w_dnPush) r_dnWrPtr <= r_dnWrPtr + 1'b1;
      if (w_rdXfer) r_dnRdPtr <= r_dnRdPtr + 1'b1;
      r_txeN     <= (w_upLevelNext == LVL_FULL);
      r_rxfN     <= (w_dnLevelNext == '0);
      r_dataOe   <= ~i_oeN;
      r_protoErr <= r_protoErr | w_contention;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_wrXfer) r_upMem[r_upWrPtr[AW-1:0]] <= {i_be, i_data};
    if (w_dnPush) r_dnMem[r_dnWrPtr[AW-1:0]] <= {i_dnBe, i_dnData};
  end

  assign w_upHead = (w_upLevel != '0) ? r_upMem[r_upRdPtr[AW-1:0]] : '0;
  assign w_dnHead = (w_dnLevel != '0) ? r_dnMem[r_dnRdPtr[AW-1:0]] : '0;

  assign o_upData   = w_upHead[WIDTH_DATA-1:0];
  assign o_upBe     = w_upHead[WW-1:WIDTH_DATA];
  assign o_upValid  = (w_upLevel != '0);
  assign o_data     = w_dnHead[WIDTH_DATA-1:0];
  assign o_be       = w_dnHead[WW-1:WIDTH_DATA];
  assign o_dataOe   = r_dataOe;
  assign o_beOe     = r_dataOe;
  assign o_txeN     = r_txeN;
  assign o_rxfN     = r_rxfN;
  assign o_upLevel  = w_upLevel;
  assign o_dnLevel  = w_dnLevel;
  assign o_protoErr = r_protoErr;

endmodule

// File: tb/tb_ft601_fifo_slv.sv
// Bench for ft601_fifo_slv: a fixed vector table, directed corner sequences and
// randomized traffic checked against a queue-based model of the bus rules.
module tb_ft601_fifo_slv;
  import pkg_ft601_ctrl_defines::*;

  localparam int DEPTH = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [WIDTH_DATA-1:0] dataIn = '0;
  logic [CNT_BE-1:0]     beIn = '0;
  logic                  wrN = 1'b1, rdN = 1'b1, oeN = 1'b1;
  logic                  upReady = 1'b0, dnValid = 1'b0;
  logic [WIDTH_DATA-1:0] dnData = '0;
  logic [CNT_BE-1:0]     dnBe = '0;

  logic [WIDTH_DATA-1:0] o_data, o_upData;
  logic [CNT_BE-1:0]     o_be, o_upBe;
  logic                  o_dataOe, o_beOe, o_txeN, o_rxfN, o_upValid, o_dnReady, o_protoErr;
  logic [4:0]            o_upLevel, o_dnLevel;

  int total = 0;
  int bad = 0;

  ft601_fifo_slv #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_data(dataIn), .o_data(o_data), .o_dataOe(o_dataOe),
    .i_be(beIn), .o_be(o_be), .o_beOe(o_beOe),
    .i_wrN(wrN), .i_rdN(rdN), .i_oeN(oeN),
    .o_txeN(o_txeN), .o_rxfN(o_rxfN),
    .o_upData(o_upData), .o_upBe(o_upBe), .o_upValid(o_upValid), .i_upReady(upReady),
    .i_dnData(dnData), .i_dnBe(dnBe), .i_dnValid(dnValid), .o_dnReady(o_dnReady),
    .o_upLevel(o_upLevel), .o_dnLevel(o_dnLevel), .o_protoErr(o_protoErr)
  );

  always #5 clk = ~clk;

  // Reference model: two queues plus the registered bus flags as the bus sees them.
  typedef struct packed {
    logic [CNT_BE-1:0]     be;
    logic [WIDTH_DATA-1:0] data;
  } word_t;

  word_t upQ[$];
  word_t dnQ[$];
  logic  mTxeN = 1'b1, mRxfN = 1'b1, mOe = 1'b0, mErr = 1'b0;

  typedef struct {
    int rst, wrN, rdN, oeN, upR, dnV;
    int eUp, eDn, eTxe, eRxf, eOe, eErr;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    upQ.delete();
    dnQ.delete();
    mTxeN = 1'b1;
    mRxfN = 1'b1;
    mOe   = 1'b0;
    mErr  = 1'b0;
  endtask

  task automatic modelEdge();
    bit cont, wr, rd, upPop, dnPush;
    if (rst) begin
      modelReset();
      return;
    end
    cont   = !wrN && (!oeN || mOe);
    wr     = !wrN && !mTxeN && oeN && !mOe;
    rd     = !rdN && !oeN && mOe && !mRxfN && wrN;
    upPop  = (upQ.size() != 0) && upReady;
    dnPush = dnValid && (dnQ.size() != DEPTH);
    if (upPop)  void'(upQ.pop_front());
    if (wr)     upQ.push_back('{be: beIn, data: dataIn});
    if (rd)     void'(dnQ.pop_front());
    if (dnPush) dnQ.push_back('{be: dnBe, data: dnData});
    mTxeN = (upQ.size() == DEPTH);
    mRxfN = (dnQ.size() == 0);
    mOe   = !oeN;
    mErr  = mErr | cont;
  endtask

  task automatic compareAll();
    word_t dnHead;
    dnHead = (dnQ.size() != 0) ? dnQ[0] : '0;
    checkOutput("txe_n", 64'(o_txeN), 64'(mTxeN));
    checkOutput("rxf_n", 64'(o_rxfN), 64'(mRxfN));
    checkOutput("data_oe", 64'(o_dataOe), 64'(mOe));
    checkOutput("be_oe", 64'(o_beOe), 64'(mOe));
    checkOutput("proto_err", 64'(o_protoErr), 64'(mErr));
    checkOutput("up_level", 64'(o_upLevel), 64'(upQ.size()));
    checkOutput("dn_level", 64'(o_dnLevel), 64'(dnQ.size()));
    checkOutput("up_valid", 64'(o_upValid), 64'(upQ.size() != 0));
    checkOutput("dn_ready", 64'(o_dnReady), 64'((dnQ.size() != DEPTH) && !rst));
    checkOutput("data_o", 64'(o_data), 64'(dnHead.data));
    checkOutput("be_o", 64'(o_be), 64'(dnHead.be));
    if (upQ.size() != 0) begin
      checkOutput("up_data", 64'(o_upData), 64'(upQ[0].data));
      checkOutput("up_be", 64'(o_upBe), 64'(upQ[0].be));
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic o, input logic ur, input logic dv);
    wrN     = w;
    rdN     = r;
    oeN     = o;
    upReady = ur;
    dnValid = dv;
  endtask

  task automatic setIdle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic resetDut();
    setIdle();
    rst = 1'b1;
    #1;
    modelReset();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic randomPhase(input int n, input bit allowErr);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0) oeN = ~oeN;
      rdN = ($urandom_range(0, 99) < 60) ? 1'b0 : 1'b1;
      if (allowErr) wrN = ($urandom_range(0, 99) < 40) ? 1'b0 : 1'b1;
      else          wrN = (oeN && !mOe && $urandom_range(0, 99) < 60) ? 1'b0 : 1'b1;
      upReady = ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0;
      dnValid = ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0;
      dataIn  = $urandom;
      beIn    = 4'($urandom);
      dnData  = $urandom;
      dnBe    = 4'($urandom);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // rst wrN rdN oeN upR dnV | up dn txe rxf oe err
    vecs[0]  = '{1, 0, 0, 0, 0, 1,  0, 0, 1, 1, 0, 0};
    vecs[1]  = '{1, 1, 0, 1, 1, 1,  0, 0, 1, 1, 0, 0};
    vecs[2]  = '{0, 1, 1, 1, 0, 0,  0, 0, 0, 1, 0, 0};
    vecs[3]  = '{0, 0, 1, 1, 0, 0,  1, 0, 0, 1, 0, 0};
    vecs[4]  = '{0, 0, 1, 1, 0, 0,  2, 0, 0, 1, 0, 0};
    vecs[5]  = '{0, 1, 1, 1, 0, 1,  2, 1, 0, 0, 0, 0};
    vecs[6]  = '{0, 1, 1, 1, 0, 1,  2, 2, 0, 0, 0, 0};
    vecs[7]  = '{0, 1, 0, 0, 0, 0,  2, 2, 0, 0, 1, 0};
    vecs[8]  = '{0, 1, 0, 0, 0, 0,  2, 1, 0, 0, 1, 0};
    vecs[9]  = '{0, 1, 0, 0, 0, 0,  2, 0, 0, 1, 1, 0};
    vecs[10] = '{0, 1, 0, 0, 0, 0,  2, 0, 0, 1, 1, 0};
    vecs[11] = '{0, 0, 1, 0, 0, 0,  2, 0, 0, 1, 1, 1};
    vecs[12] = '{0, 0, 1, 1, 0, 0,  2, 0, 0, 1, 0, 1};
    vecs[13] = '{0, 0, 1, 1, 0, 0,  3, 0, 0, 1, 0, 1};
    vecs[14] = '{0, 1, 1, 1, 1, 0,  2, 0, 0, 1, 0, 1};
    vecs[15] = '{0, 0, 1, 1, 1, 0,  2, 0, 0, 1, 0, 1};

    for (int i = 0; i < 16; i++) begin
      rst = 1'(vecs[i].rst);
      applyStimulus(1'(vecs[i].wrN), 1'(vecs[i].rdN), 1'(vecs[i].oeN), 1'(vecs[i].upR), 1'(vecs[i].dnV));
      dataIn = 32'h5000 + 32'(i);
      dnData = 32'hD000 + 32'(i);
      @(posedge clk);
      #1;
      checkOutput("vec_up_level", 64'(o_upLevel), 64'(vecs[i].eUp));
      checkOutput("vec_dn_level", 64'(o_dnLevel), 64'(vecs[i].eDn));
      checkOutput("vec_txe_n", 64'(o_txeN), 64'(vecs[i].eTxe));
      checkOutput("vec_rxf_n", 64'(o_rxfN), 64'(vecs[i].eRxf));
      checkOutput("vec_data_oe", 64'(o_dataOe), 64'(vecs[i].eOe));
      checkOutput("vec_proto_err", 64'(o_protoErr), 64'(vecs[i].eErr));
    end

    // Write burst: 20 strobes into a 16-deep buffer, then drain in order.
    resetDut();
    for (int i = 0; i < 20; i++) begin
      wrN    = 1'b0;
      dataIn = 32'h1000 + 32'(i);
      beIn   = 4'hF;
      step();
      if (i == 15) checkOutput("burst_txe_full", 64'(o_txeN), 64'd1);
    end
    wrN = 1'b1;
    checkOutput("burst_level", 64'(o_upLevel), 64'd16);
    upReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput("drain_order", 64'(o_upData), 64'(32'h1000 + 32'(i)));
      step();
    end
    checkOutput("drain_empty", 64'(o_upValid), 64'd0);

    // Read burst: five words, OE_N first, then eight read strobes.
    setIdle();
    for (int k = 0; k < 5; k++) begin
      dnValid = 1'b1;
      dnData  = 32'hA0 + 32'(k);
      dnBe    = 4'(k + 1);
      step();
    end
    dnValid = 1'b0;
    oeN = 1'b0;
    step();
    checkOutput("rd_oe_on", 64'(o_dataOe), 64'd1);
    checkOutput("rd_no_pop_first", 64'(o_dnLevel), 64'd5);
    rdN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("rd_data", 64'(o_data), (i < 5) ? 64'(32'hA0 + 32'(i)) : 64'd0);
      step();
      if (i == 4) begin
        checkOutput("rd_rxf_empty", 64'(o_rxfN), 64'd1);
        checkOutput("rd_level_zero", 64'(o_dnLevel), 64'd0);
      end
    end

    // Full upstream with a local pop and a master write on the same edge.
    setIdle();
    step();
    for (int i = 0; i < 16; i++) begin
      wrN    = 1'b0;
      dataIn = $urandom;
      step();
    end
    upReady = 1'b1;
    step();
    checkOutput("fc_level", 64'(o_upLevel), 64'd15);
    checkOutput("fc_txe_back", 64'(o_txeN), 64'd0);
    step();
    checkOutput("fc_level_hold", 64'(o_upLevel), 64'd15);

    // Contention: write strobe together with OE_N low.
    setIdle();
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("cont_err", 64'(o_protoErr), 64'd1);
    checkOutput("cont_no_write", 64'(o_upLevel), 64'd15);
    setIdle();
    for (int i = 0; i < 4; i++) step();
    checkOutput("cont_sticky", 64'(o_protoErr), 64'd1);

    // Reset in the middle of an active read.
    resetDut();
    for (int k = 0; k < 3; k++) begin
      dnValid = 1'b1;
      dnData  = 32'hC0 + 32'(k);
      step();
    end
    dnValid = 1'b0;
    oeN = 1'b0;
    step();
    rdN = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_oe", 64'(o_dataOe), 64'd0);
    checkOutput("mid_rst_level", 64'(o_dnLevel), 64'd0);
    checkOutput("mid_rst_rxf", 64'(o_rxfN), 64'd1);
    checkOutput("mid_rst_data", 64'(o_data), 64'd0);
    checkOutput("mid_rst_err", 64'(o_protoErr), 64'd0);
    modelReset();
    setIdle();
    step();
    rst = 1'b0;
    step();

    randomPhase(300, 1'b0);
    resetDut();
    randomPhase(300, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
